prco_alu_seq: RTL

Parametrised, handshaked successor ALU for the prco core execute stage. It executes single-cycle arithmetic, logic, shift and compare operations in one cycle. Unsigned multiply and divide run iteratively over WIDTH cycles. Every result is delivered with a one-cycle valid pulse, routed to either the register-writeback or the RAM-access stage. A flags register (Z/S/O/C) is kept for the compare and branch logic.

---
 rtl/prco_alu_seq.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/prco_alu_seq.sv
// prco_alu_seq: execute-stage ALU for the prco core.
// Single-cycle ops finish in IDLE; MUL/DIV iterate one bit per cycle.
module prco_alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             q_ready,
    input  logic             i_req_ram,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_datb,
    input  logic [7:0]       i_imm,
    output logic [WIDTH-1:0] q_result,
    output logic [3:0]       q_flags,
    output logic             q_ce_reg,
    output logic             q_ce_ram,
    output logic             q_div0
);
    localparam int SW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_MOV  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_CMP  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_MEMA = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             div_q, div_d;
    logic             ram_q, ram_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             ce_reg_q, ce_reg_d;
    logic             ce_ram_q, ce_ram_d;
    logic             div0_q, div0_d;

    logic [WIDTH-1:0] imm_x;
    logic [SW-1:0]    sh;
    logic [WIDTH:0]   add_w, sub_w, addi_w, mema_w;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_o, alu_f;

    assign imm_x = WIDTH'($signed(i_imm));
    assign sh    = i_datb[SW-1:0];

    always_comb begin
        add_w  = {1'b0, i_data} + {1'b0, i_datb};
        sub_w  = {1'b0, i_data} - {1'b0, i_datb};
        addi_w = {1'b0, i_datb} + {1'b0, imm_x};
        mema_w = {1'b0, i_data} + {1'b0, imm_x};
        alu_r  = '0;
        alu_c  = 1'b0;
        alu_o  = 1'b0;
        alu_f  = 1'b0;
        unique case (i_op)
            OP_ADD: begin
                alu_r = add_w[M:0];
                alu_c = add_w[WIDTH];
                alu_o = (i_data[M] == i_datb[M]) && (alu_r[M] != i_data[M]);
                alu_f = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_r = sub_w[M:0];
                alu_c = sub_w[WIDTH];
                alu_o = (i_data[M] != i_datb[M]) && (alu_r[M] != i_data[M]);
                alu_f = 1'b1;
            end
            OP_ADDI: begin
                alu_r = addi_w[M:0];
                alu_c = addi_w[WIDTH];
                alu_o = (i_datb[M] == imm_x[M]) && (alu_r[M] != i_datb[M]);
                alu_f = 1'b1;
            end
            OP_AND:  alu_r = i_data & i_datb;
            OP_OR:   alu_r = i_data | i_datb;
            OP_XOR:  alu_r = i_data ^ i_datb;
            OP_MOV:  alu_r = i_datb;
            OP_SHL:  alu_r = i_data << sh;
            OP_SHR:  alu_r = i_data >> sh;
            OP_ASR:  alu_r = $signed(i_data) >>> sh;
            OP_MEMA: alu_r = mema_w[M:0];
            default: alu_r = '0;
        endcase
    end

    // One iteration: shift-add multiply, or restoring divide where
    // opa_q shifts dividend bits out and quotient bits in.
    logic [WIDTH-1:0] mul_acc, div_quo, div_rem;
    logic [WIDTH:0]   div_sh, div_dif;
    logic             div_ge;

    always_comb begin
        mul_acc = opb_q[0] ? acc_q + opa_q : acc_q;
        div_sh  = {acc_q, opa_q[M]};
        div_ge  = div_sh >= {1'b0, opb_q};
        div_dif = div_sh - {1'b0, opb_q};
        div_rem = div_ge ? div_dif[M:0] : div_sh[M:0];
        div_quo = {opa_q[M-1:0], div_ge};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        div_d    = div_q;
        ram_d    = ram_q;
        result_d = result_q;
        flags_d  = flags_q;
        ce_reg_d = 1'b0;
        ce_ram_d = 1'b0;
        div0_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (i_op == OP_MUL || (i_op == OP_DIV && i_datb != '0)) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        opa_d   = i_data;
                        opb_d   = i_datb;
                        acc_d   = '0;
                        div_d   = (i_op == OP_DIV);
                        ram_d   = i_req_ram;
                    end else begin
                        result_d = alu_r;
                        ce_reg_d = !i_req_ram;
                        ce_ram_d = i_req_ram;
                        if (alu_f) begin
                            flags_d = {alu_c, alu_o, alu_r[M], alu_r == '0};
                        end
                        // divide by zero reports at once, then idles a cycle in DONE
                        if (i_op == OP_DIV) begin
                            result_d = '1;
                            div0_d   = 1'b1;
                            state_d  = S_DONE;
                        end
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (div_q) begin
                    opa_d = div_quo;
                    acc_d = div_rem;
                end else begin
                    acc_d = mul_acc;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    result_d = div_q ? div_quo : mul_acc;
                    ce_reg_d = !ram_q;
                    ce_ram_d = ram_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            div_q    <= 1'b0;
            ram_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            ce_reg_q <= 1'b0;
            ce_ram_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            div_q    <= div_d;
            ram_q    <= ram_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            ce_reg_q <= ce_reg_d;
            ce_ram_q <= ce_ram_d;
            div0_q   <= div0_d;
        end
    end

    assign q_ready  = (state_q == S_IDLE);
    assign q_result = result_q;
    assign q_flags  = flags_q;
    assign q_ce_reg = ce_reg_q;
    assign q_ce_ram = ce_ram_q;
    assign q_div0   = div0_q;
endmodule
